// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared definitions for the TMDS receive path: DVI control
//                token codes, receiver state type and token helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam int unsigned c_NUM_OFFSETS = 10;

    // Control tokens, written q[9:0]; bit 0 is the earliest serial bit.
    localparam logic [9:0] c_TOKEN_CTRL0 = 10'b1101010100;
    localparam logic [9:0] c_TOKEN_CTRL1 = 10'b0010101011;
    localparam logic [9:0] c_TOKEN_CTRL2 = 10'b0101010100;
    localparam logic [9:0] c_TOKEN_CTRL3 = 10'b1010101011;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tmds_rx_state_t;

    // True when the aligned symbol is one of the four control tokens.
    function automatic logic tmds_is_token(input logic [9:0] sym);
        return (sym == c_TOKEN_CTRL0) || (sym == c_TOKEN_CTRL1) ||
               (sym == c_TOKEN_CTRL2) || (sym == c_TOKEN_CTRL3);
    endfunction

    // Control value {c1,c0} carried by a token; 0 for anything else.
    function automatic logic [1:0] tmds_token_ctrl(input logic [9:0] sym);
        logic [1:0] ctrl;
        case (sym)
            c_TOKEN_CTRL0: ctrl = 2'b00;
            c_TOKEN_CTRL1: ctrl = 2'b01;
            c_TOKEN_CTRL2: ctrl = 2'b10;
            c_TOKEN_CTRL3: ctrl = 2'b11;
            default:       ctrl = 2'b00;
        endcase
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_symbol_decode
//  Description : Combinational decode of one aligned 10-bit TMDS symbol into
//                either a control value or an 8-bit data byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] w_b;

    assign is_ctrl = tmds_is_token(sym);
    assign ctrl    = tmds_token_ctrl(sym);

    // q[9] flags that the encoder inverted the payload bits.
    assign w_b = sym[9] ? ~sym[7:0] : sym[7:0];

    // Undo the XOR/XNOR transition chain selected by q[8].
    always_comb begin
        data    = '0;
        data[0] = w_b[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (w_b[i] ^ w_b[i-1]) : ~(w_b[i] ^ w_b[i-1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : TMDS receiver: hunts for the word-boundary offset using DVI
//                control tokens, then decodes aligned symbols to pixel data
//                or control values with a video-enable flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    input  logic       tmds_valid_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       dec_valid_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);

    localparam int c_RUN_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int c_IDLE_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

    tmds_rx_state_t        r_state, w_state_nxt;
    logic [9:0]            r_prev;
    logic [c_RUN_W-1:0]    r_run_cnt, w_run_nxt;
    logic [c_IDLE_W-1:0]   r_idle_cnt, w_idle_nxt;
    logic [3:0]            r_offset, w_offset_nxt;
    logic [7:0]            r_data, w_data_nxt;
    logic [1:0]            r_control, w_control_nxt;
    logic                  r_ve, w_ve_nxt;
    logic                  r_dec_valid, w_dec_valid_nxt;

    // Bit 19 of the full window is never part of any candidate.
    logic [18:0]           w_window;
    logic [9:0]            w_cand [c_NUM_OFFSETS];
    logic [c_NUM_OFFSETS-1:0] w_hit;
    logic                  w_any_hit;
    logic [3:0]            w_low_off, w_hunt_off, w_dec_off;
    logic [31:0]           w_run_ext;
    logic                  w_emit;
    logic [9:0]            w_sym;
    logic                  w_dec_is_ctrl;
    logic [1:0]            w_dec_ctrl;
    logic [7:0]            w_dec_data;

    assign w_window = {tmds_in[8:0], r_prev};

    for (genvar k = 0; k < c_NUM_OFFSETS; k++) begin : g_offset
        assign w_cand[k] = w_window[k +: 10];
        assign w_hit[k]  = tmds_is_token(w_cand[k]);
    end

    // Lowest offset holding a token this cycle.
    always_comb begin
        w_low_off = '0;
        for (int k = c_NUM_OFFSETS - 1; k >= 0; k--) begin
            if (w_hit[k]) w_low_off = 4'(k);
        end
    end

    assign w_any_hit  = |w_hit;
    // The current candidate keeps priority over any other matching offset.
    assign w_hunt_off = w_hit[r_offset] ? r_offset :
                        (w_any_hit ? w_low_off : r_offset);
    // The lock-completing word is decoded at the offset it locks to.
    assign w_dec_off  = (r_state == LOCKED) ? r_offset : w_hunt_off;
    assign w_sym      = w_cand[w_dec_off];

    tmds_symbol_decode u_symbol_decode (
        .sym     (w_sym),
        .is_ctrl (w_dec_is_ctrl),
        .ctrl    (w_dec_ctrl),
        .data    (w_dec_data)
    );

    // State, counters, window history and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= HUNT;
            r_prev      <= '0;
            r_run_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_offset    <= '0;
            r_data      <= '0;
            r_control   <= '0;
            r_ve        <= 1'b0;
            r_dec_valid <= 1'b0;
        end else begin
            if (tmds_valid_in) r_prev <= tmds_in;
            r_state     <= w_state_nxt;
            r_run_cnt   <= w_run_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_offset    <= w_offset_nxt;
            r_data      <= w_data_nxt;
            r_control   <= w_control_nxt;
            r_ve        <= w_ve_nxt;
            r_dec_valid <= w_dec_valid_nxt;
        end
    end

    // Next state: token-run counting in HUNT, idle timeout in LOCKED.
    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run_cnt;
        w_idle_nxt   = r_idle_cnt;
        w_offset_nxt = r_offset;
        w_run_ext    = '0;
        w_emit       = 1'b0;
        if (tmds_valid_in) begin
            case (r_state)
                HUNT: begin
                    w_offset_nxt = w_hunt_off;
                    if (w_hit[r_offset])  w_run_ext = 32'(r_run_cnt) + 32'd1;
                    else if (w_any_hit)   w_run_ext = 32'd1;
                    else                  w_run_ext = 32'd0;
                    if (w_run_ext == 32'(LOCK_COUNT)) begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = '0;
                        w_idle_nxt  = '0;
                        w_emit      = 1'b1;
                    end else begin
                        w_run_nxt   = w_run_ext[c_RUN_W-1:0];
                    end
                end
                LOCKED: begin
                    if (w_dec_is_ctrl) begin
                        w_idle_nxt = '0;
                        w_emit     = 1'b1;
                    end else if (32'(r_idle_cnt) + 32'd1 == 32'(TIMEOUT)) begin
                        w_state_nxt = HUNT;
                        w_run_nxt   = '0;
                        w_idle_nxt  = '0;
                    end else begin
                        w_idle_nxt = r_idle_cnt + c_IDLE_W'(1);
                        w_emit     = 1'b1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Output update: control words leave data untouched and vice versa.
    always_comb begin
        w_data_nxt      = r_data;
        w_control_nxt   = r_control;
        w_ve_nxt        = r_ve;
        w_dec_valid_nxt = w_emit;
        if (w_emit) begin
            if (w_dec_is_ctrl) begin
                w_control_nxt = w_dec_ctrl;
                w_ve_nxt      = 1'b0;
            end else begin
                w_data_nxt    = w_dec_data;
                w_ve_nxt      = 1'b1;
            end
        end
    end

    assign data_out      = r_data;
    assign control_out   = r_control;
    assign ve_out        = r_ve;
    assign dec_valid_out = r_dec_valid;
    assign locked_out    = (r_state == LOCKED);
    assign offset_out    = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_decoder
//  Description : Directed self-checking bench for tmds_decoder. At offset k
//                the candidate symbol starts at bit k of the previous word, so
//                each symbol is judged on the cycle after its last bit arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

    localparam logic [9:0] T00  = 10'b1101010100;
    localparam logic [9:0] T01  = 10'b0010101011;
    localparam logic [9:0] T10  = 10'b0101010100;
    localparam logic [9:0] T11  = 10'b1010101011;
    // Hand-encoded data symbols: {q9,q8,q[7:0]}
    localparam logic [9:0] D_A5 = 10'h163;   // XOR chain, not inverted
    localparam logic [9:0] D_00 = 10'h100;   // XOR chain, not inverted
    localparam logic [9:0] D_FF = 10'h200;   // XNOR chain, inverted
    localparam logic [9:0] D_5A = 10'h263;   // XNOR chain, inverted

    logic       clk_in;
    logic       rst_in;
    logic [9:0] tmds_in;
    logic       tmds_valid_in;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       dec_valid_out;
    logic       locked_out;
    logic [3:0] offset_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;

    tmds_decoder #(.LOCK_COUNT(8), .TIMEOUT(4096)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .tmds_in       (tmds_in),
        .tmds_valid_in (tmds_valid_in),
        .data_out      (data_out),
        .control_out   (control_out),
        .ve_out        (ve_out),
        .dec_valid_out (dec_valid_out),
        .locked_out    (locked_out),
        .offset_out    (offset_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [9:0] w, input logic v);
        tmds_in       = w;
        tmds_valid_in = v;
        @(posedge clk_in);
        #1;
        if (dec_valid_out === 1'b1) n_strobe++;
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        tmds_valid_in = 1'b0;
        tmds_in       = '0;
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        n_strobe = 0;
    endtask

    task automatic lock_aligned();
        do_reset();
        for (int i = 0; i < 9; i++) send(T01, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        send(10'h155, 1'b0);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
        n_checks++; if (control_out !== 2'b00) begin n_fail++; $display("FAIL reset_control: got %b expected 00", control_out); end
        n_checks++; if (ve_out !== 1'b0) begin n_fail++; $display("FAIL reset_ve: got %b expected 0", ve_out); end
        n_checks++; if (dec_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dec_valid_out); end
        n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked_out); end
        n_checks++; if (offset_out !== 4'd0) begin n_fail++; $display("FAIL reset_offset: got %0d expected 0", offset_out); end
    endtask

    task automatic test_aligned();
        do_reset();
        for (int i = 0; i < 8; i++) send(T01, 1'b1);
        n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL aligned_prelock_strobes: got %0d expected 0", n_strobe); end
        send(D_A5, 1'b1);   // eighth token, now in the previous-word slot
        n_checks++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL aligned_locked: got %b expected 1", locked_out); end
        n_checks++; if (offset_out !== 4'd0) begin n_fail++; $display("FAIL aligned_offset: got %0d expected 0", offset_out); end
        n_checks++; if (dec_valid_out !== 1'b1) begin n_fail++; $display("FAIL aligned_lock_strobe: got %b expected 1", dec_valid_out); end
        n_checks++; if (ve_out !== 1'b0) begin n_fail++; $display("FAIL aligned_lock_ve: got %b expected 0", ve_out); end
        n_checks++; if (control_out !== 2'b01) begin n_fail++; $display("FAIL aligned_lock_ctrl: got %b expected 01", control_out); end
        send(T01, 1'b1);
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL aligned_data: got %h expected a5", data_out); end
        n_checks++; if (ve_out !== 1'b1) begin n_fail++; $display("FAIL aligned_data_ve: got %b expected 1", ve_out); end
        n_checks++; if (control_out !== 2'b01) begin n_fail++; $display("FAIL aligned_ctrl_hold: got %b expected 01", control_out); end
        n_checks++; if (n_strobe !== 2) begin n_fail++; $display("FAIL aligned_strobes: got %0d expected 2", n_strobe); end
    endtask

    task automatic test_misaligned();
        logic [9:0]   syms [12];
        logic [129:0] bits;
        logic [9:0]   words [12];
        logic [7:0]   exp_data [3];
        for (int m = 0; m < 8; m++) syms[m] = T01;
        syms[8] = D_00; syms[9] = D_FF; syms[10] = D_5A; syms[11] = T01;
        exp_data[0] = 8'h00; exp_data[1] = 8'hFF; exp_data[2] = 8'h5A;
        bits = '0;
        for (int m = 0; m < 12; m++) bits[3 + 10*m +: 10] = syms[m];
        for (int n = 0; n < 12; n++) words[n] = bits[10*n +: 10];
        do_reset();
        for (int n = 0; n < 8; n++) send(words[n], 1'b1);
        n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL misaligned_prelock: got %b expected 0", locked_out); end
        n_checks++; if (offset_out !== 4'd3) begin n_fail++; $display("FAIL misaligned_candidate: got %0d expected 3", offset_out); end
        send(words[8], 1'b1);
        n_checks++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL misaligned_locked: got %b expected 1", locked_out); end
        n_checks++; if (offset_out !== 4'd3) begin n_fail++; $display("FAIL misaligned_offset: got %0d expected 3", offset_out); end
        for (int n = 0; n < 3; n++) begin
            send(words[9 + n], 1'b1);
            n_checks++; if (data_out !== exp_data[n] || ve_out !== 1'b1 || dec_valid_out !== 1'b1) begin
                n_fail++; $display("FAIL misaligned_data%0d: got %h ve %b dv %b expected %h ve 1 dv 1", n, data_out, ve_out, dec_valid_out, exp_data[n]);
            end
        end
    endtask

    task automatic test_short_run();
        do_reset();
        for (int i = 0; i < 7; i++) send(T01, 1'b1);
        send(D_A5, 1'b1);
        for (int i = 0; i < 8; i++) send(T01, 1'b1);
        n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL short_run_locked: got %b expected 0", locked_out); end
        n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL short_run_strobes: got %0d expected 0", n_strobe); end
        send(T01, 1'b1);
        n_checks++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL short_run_relock: got %b expected 1", locked_out); end
    endtask

    task automatic test_timeout();
        lock_aligned();
        for (int i = 0; i < 4095; i++) send(D_A5, 1'b1);
        send(D_A5, 1'b1);   // 4095th data symbol judged
        n_checks++; if (locked_out !== 1'b1 || dec_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL timeout_before: locked %b dv %b expected 1 1", locked_out, dec_valid_out);
        end
        send(D_A5, 1'b1);   // 4096th data symbol judged
        n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL timeout_drop: got %b expected 0", locked_out); end
        n_checks++; if (dec_valid_out !== 1'b0) begin n_fail++; $display("FAIL timeout_no_strobe: got %b expected 0", dec_valid_out); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL timeout_data_hold: got %h expected a5", data_out); end
    endtask

    task automatic test_timeout_keep();
        lock_aligned();
        for (int i = 0; i < 4094; i++) send(D_A5, 1'b1);
        send(T11, 1'b1);    // token is the 4095th word
        send(D_A5, 1'b1);
        n_checks++; if (ve_out !== 1'b0 || control_out !== 2'b11) begin
            n_fail++; $display("FAIL keep_token: ve %b ctrl %b expected 0 11", ve_out, control_out);
        end
        send(D_A5, 1'b1);
        send(D_A5, 1'b1);
        n_checks++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL keep_locked: got %b expected 1", locked_out); end
    endtask

    task automatic test_gapped();
        logic [9:0] seq [10];
        for (int i = 0; i < 8; i++) seq[i] = T01;
        seq[8] = D_A5; seq[9] = T01;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(seq[i], 1'b1);
            if (i == 7) begin
                n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL gapped_prelock: got %b expected 0", locked_out); end
            end
            if (i == 8) begin
                n_checks++; if (locked_out !== 1'b1 || control_out !== 2'b01 || dec_valid_out !== 1'b1) begin
                    n_fail++; $display("FAIL gapped_lock: locked %b ctrl %b dv %b expected 1 01 1", locked_out, control_out, dec_valid_out);
                end
            end
            if (i == 9) begin
                n_checks++; if (data_out !== 8'hA5 || ve_out !== 1'b1) begin
                    n_fail++; $display("FAIL gapped_data: got %h ve %b expected a5 1", data_out, ve_out);
                end
            end
            send(10'h3C7, 1'b0);
            n_checks++; if (dec_valid_out !== 1'b0) begin n_fail++; $display("FAIL gapped_idle_dv%0d: got %b expected 0", i, dec_valid_out); end
        end
        n_checks++; if (n_strobe !== 2) begin n_fail++; $display("FAIL gapped_strobes: got %0d expected 2", n_strobe); end
    endtask

    task automatic test_reset_mid_lock();
        lock_aligned();
        send(D_A5, 1'b1);
        send(T10, 1'b1);
        rst_in = 1'b1; tmds_in = T01; tmds_valid_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        n_checks++; if ({data_out, control_out, ve_out, dec_valid_out, locked_out, offset_out} !== 17'd0) begin
            n_fail++; $display("FAIL midreset_outputs: data %h ctrl %b ve %b dv %b lk %b off %0d expected all 0",
                               data_out, control_out, ve_out, dec_valid_out, locked_out, offset_out);
        end
        for (int i = 0; i < 7; i++) send(T01, 1'b1);
        n_checks++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL midreset_early: got %b expected 0", locked_out); end
        send(T01, 1'b1);
        send(T01, 1'b1);
        n_checks++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL midreset_relock: got %b expected 1", locked_out); end
    endtask

    task automatic test_control_tokens();
        lock_aligned();
        send(T00, 1'b1);
        n_checks++; if (control_out !== 2'b01) begin n_fail++; $display("FAIL ctrl_01: got %b expected 01", control_out); end
        send(T10, 1'b1);
        n_checks++; if (control_out !== 2'b00) begin n_fail++; $display("FAIL ctrl_00: got %b expected 00", control_out); end
        send(T11, 1'b1);
        n_checks++; if (control_out !== 2'b10) begin n_fail++; $display("FAIL ctrl_10: got %b expected 10", control_out); end
        send(D_A5, 1'b1);
        n_checks++; if (control_out !== 2'b11) begin n_fail++; $display("FAIL ctrl_11: got %b expected 11", control_out); end
        send(T01, 1'b1);
        n_checks++; if (data_out !== 8'hA5 || control_out !== 2'b11 || ve_out !== 1'b1) begin
            n_fail++; $display("FAIL ctrl_data_hold: data %h ctrl %b ve %b expected a5 11 1", data_out, control_out, ve_out);
        end
        send(T01, 1'b1);
        n_checks++; if (control_out !== 2'b01 || data_out !== 8'hA5 || ve_out !== 1'b0) begin
            n_fail++; $display("FAIL ctrl_after_data: ctrl %b data %h ve %b expected 01 a5 0", control_out, data_out, ve_out);
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        tmds_in       = '0;
        tmds_valid_in = 1'b0;
        test_reset();
        test_aligned();
        test_misaligned();
        test_short_run();
        test_timeout();
        test_timeout_keep();
        test_gapped();
        test_reset_mid_lock();
        test_control_tokens();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side counterpart of the TMDS encoder in the HDMI path. It takes one 10-bit raw TMDS word per valid cycle from a deserializer whose word boundary is arbitrary, hunts for DVI control tokens to find the bit offset, and then decodes each aligned symbol. For every word it outputs either 8-bit pixel data or the 2-bit control value, plus a video-enable flag. It is used for loopback and self-check of the video output pipeline.

## Interface
Parameters:
- `LOCK_COUNT`, default 8: consecutive control tokens at one offset required to lock.
- `TIMEOUT`, default 4096: consecutive valid words with no control token at the locked offset before lock is dropped. Must exceed one 720p line (1650).

Ports:
- `clk_in`  input  1: pixel clock. Single clock domain.
- `rst_in`  input  1: reset, synchronous, active-high.
- `tmds_in`  input  10: raw word. Bit 0 is the earliest serial bit.
- `tmds_valid_in`  input  1: `tmds_in` is a new word this cycle.
- `data_out`  output  8: decoded pixel byte.
- `control_out`  output  2: decoded control value {c1,c0}.
- `ve_out`  output  1: 1 when the current symbol is data, 0 when it is a control token.
- `dec_valid_out`  output  1: single-cycle strobe; the decoded outputs are new.
- `locked_out`  output  1: alignment is locked.
- `offset_out`  output  4: current or candidate bit offset, 0–9.

## Operation
- **Window.** Register `prev` holds the last accepted word. The 20-bit window is {tmds_in, prev}. The candidate at offset k is window[k+9:k], for k = 0..9.
- **Control tokens.** The four tokens are 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011. Each of the 10 offsets is compared every valid cycle. If several offsets match, the lowest one wins.
- **States.** There are two states, HUNT and LOCKED. Both `run_cnt` and `idle_cnt` are sized by $clog2.
- **HUNT.** On each valid cycle:
  - If the candidate offset matches, `run_cnt` increments.
  - Else, if another offset matches, the candidate becomes the lowest matching offset and `run_cnt` is set to 1.
  - Else `run_cnt` is set to 0.
  - When `run_cnt` would reach LOCK_COUNT, go to LOCKED with that offset and clear `idle_cnt`.
- **LOCKED.** On each valid cycle, the symbol at the locked offset is decoded:
  - **Control token:** set `control_out`, set `ve_out`=0, hold `data_out`, clear `idle_cnt`.
  - **Data symbol q:** set `b` = q[9] ? ~q[7:0] : q[7:0]. Then d[0] = b[0], and for i = 1..7, d[i] = q[8] ? b[i]^b[i-1] : ~(b[i]^b[i-1]). Set `ve_out`=1, hold `control_out`, and increment `idle_cnt`.
  - **Timeout:** when `idle_cnt` would reach TIMEOUT, go to HUNT. Clear `run_cnt`; `locked_out` falls. No strobe is issued for that word.
- **Token at another offset while LOCKED:** ignored, because only the timeout drops lock.
- **Invalid cycles:** when `tmds_valid_in`=0, `prev`, the state, and the counters all hold, and `dec_valid_out`=0.
- **Strobe:** `dec_valid_out` pulses only in LOCKED. This includes the word that completes the lock, which is decoded at the new offset.
- **Reset values:** all outputs 0, state HUNT, `prev`=0, and both counters 0. Reset in the middle of a lock returns to HUNT on the next edge.

## Timing
- **Latency:** all outputs are registered on the edge that ends the valid cycle, so results are visible one cycle later.
- **Lock:** `locked_out` rises on the edge after the LOCK_COUNT-th consecutive token is accepted.
- **Throughput:** one word per cycle, with no backpressure.
- **Offset k>0:** the first aligned symbol needs two accepted words. The symbol spanning `prev`/`tmds_in` is emitted when its second half arrives.

## Structure
- Package `tmds_pkg` holds:
  - the four control-token constants,
  - the state enum `tmds_rx_state_t` {HUNT, LOCKED},
  - a function mapping token→control value.
- Sub-module `tmds_symbol_decode` is purely combinational. It takes a 10-bit aligned symbol and produces `is_ctrl`, `ctrl[1:0]` and `data[7:0]`. It is instantiated once for the decode path. The 10-offset hunt compare uses the package function.

## Test plan
- **Aligned lock and decode:** 8× token 0010101011 at offset 0, then the encoder output for 0xA5. Required: `locked_out`=1 after the 8th token, and `offset_out`=0; the 0xA5 word gives `data_out`=0xA5, `ve_out`=1 and one strobe.
- **Misaligned lock:** the same bit stream delayed by 3 bits across word boundaries. Required: lock with `offset_out`=3, and the following data words decode to 0x00, 0xFF, 0x5A in order.
- **Short run:** 7 tokens, then one data word, then 7 tokens. Required: `locked_out` stays 0 and no strobes occur. An 8th consecutive token then locks.
- **Timeout:** after lock, 4096 data words with no token. Required: `locked_out` falls on the edge after the 4096th word. A token at word 4095 instead keeps the lock.
- **Gapped valid:** the aligned-lock-and-decode stream with `tmds_valid_in` low on alternate cycles. Required: an identical decoded sequence and lock point, with strobes only after valid cycles.
- **Reset mid-lock:** while locked, assert `rst_in` for 1 cycle. Required: all outputs 0 on the next cycle, and relock takes 8 fresh tokens.
